// File: rtl/proc_pkg.sv
// Shared ISA constants for the decode stage: opcodes, field positions and D/X field widths.
package proc_pkg;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam int unsigned OPCODE_LSB = 27;
  localparam int unsigned RD_LSB     = 22;
  localparam int unsigned RS_LSB     = 17;
  localparam int unsigned RT_LSB     = 12;
  localparam int unsigned SHAMT_LSB  = 7;
  localparam int unsigned ALUOP_LSB  = 2;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned TARGET_LSB = 0;

  localparam int unsigned INSN_W   = 32;
  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned ALUOP_W  = 5;
  localparam int unsigned IMM_W    = 17;
  localparam int unsigned TARGET_W = 27;
  localparam int unsigned CNT_W    = 32;

  localparam logic [4:0] R_STATUS = 5'd30;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check of the F/D instruction against a load in execute.
module load_use_detect
  import proc_pkg::*;
(
  input  logic [INSN_W-1:0] fd_insn,
  input  logic              fd_valid,
  input  logic              x_is_load,
  input  logic [REG_W-1:0]  x_rd,
  output logic              stall
);

  logic [OPCODE_W-1:0] opcode;
  logic [REG_W-1:0]    rd, rs, rt;
  logic                use_rd, use_rs, use_rt, use_status;
  logic                unused_low_bits;

  assign opcode = fd_insn[OPCODE_LSB +: OPCODE_W];
  assign rd     = fd_insn[RD_LSB +: REG_W];
  assign rs     = fd_insn[RS_LSB +: REG_W];
  assign rt     = fd_insn[RT_LSB +: REG_W];
  assign unused_low_bits = ^fd_insn[RT_LSB-1:0];

  always_comb begin
    use_rd     = 1'b0;
    use_rs     = 1'b0;
    use_rt     = 1'b0;
    use_status = 1'b0;
    case (opcode)
      OP_R:                  begin use_rs = 1'b1; use_rt = 1'b1; end
      OP_ADDI, OP_LW:        use_rs = 1'b1;
      OP_SW, OP_BNE, OP_BLT: begin use_rd = 1'b1; use_rs = 1'b1; end
      OP_JR:                 use_rd = 1'b1;
      OP_BEX:                use_status = 1'b1;
      default: ;
    endcase
  end

  // r0 is hardwired, so a load targeting it can never feed a dependent.
  assign stall = fd_valid & x_is_load & (x_rd != '0) &
                 ((use_rd & (x_rd == rd)) | (use_rs & (x_rd == rs)) |
                  (use_rt & (x_rd == rt)) | (use_status & (x_rd == R_STATUS)));

endmodule

// File: rtl/decode_stage.sv
// Decode stage: F/D register, field split, load-use stall, D/X register and stall counter.
module decode_stage
  import proc_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                f_valid,
  input  logic [W-1:0]        f_insn,
  input  logic [W-1:0]        f_pc,
  input  logic                x_is_load,
  input  logic [REG_W-1:0]    x_rd,
  input  logic                flush,
  output logic                stall_f,
  output logic                dx_valid,
  output logic [OPCODE_W-1:0] dx_opcode,
  output logic [REG_W-1:0]    dx_rd,
  output logic [REG_W-1:0]    dx_rs,
  output logic [REG_W-1:0]    dx_rt,
  output logic [SHAMT_W-1:0]  dx_shamt,
  output logic [ALUOP_W-1:0]  dx_aluop,
  output logic [IMM_W-1:0]    dx_imm17,
  output logic [TARGET_W-1:0] dx_target,
  output logic [W-1:0]        dx_pc,
  output logic [CNT_W-1:0]    stall_count
);

  logic             fd_valid;
  logic [W-1:0]     fd_insn, fd_pc;
  logic             dx_valid_q;
  logic [W-1:0]     dx_insn, dx_pc_q;
  logic [CNT_W-1:0] stall_cnt;

  load_use_detect u_hazard (
    .fd_insn  (fd_insn),
    .fd_valid (fd_valid),
    .x_is_load(x_is_load),
    .x_rd     (x_rd),
    .stall    (stall_f)
  );

  // Flush wins over stall; invalid F/D entries enter D/X as all-zero bubbles.
  always_ff @(posedge clock) begin
    if (reset) begin
      fd_valid   <= 1'b0;
      fd_insn    <= '0;
      fd_pc      <= '0;
      dx_valid_q <= 1'b0;
      dx_insn    <= '0;
      dx_pc_q    <= '0;
      stall_cnt  <= '0;
    end else if (flush) begin
      fd_valid   <= 1'b0;
      fd_insn    <= '0;
      fd_pc      <= '0;
      dx_valid_q <= 1'b0;
      dx_insn    <= '0;
      dx_pc_q    <= '0;
    end else if (stall_f) begin
      dx_valid_q <= 1'b0;
      dx_insn    <= '0;
      dx_pc_q    <= '0;
      stall_cnt  <= stall_cnt + 1'b1;
    end else begin
      fd_valid   <= f_valid;
      fd_insn    <= f_insn;
      fd_pc      <= f_pc;
      dx_valid_q <= fd_valid;
      dx_insn    <= fd_valid ? fd_insn : '0;
      dx_pc_q    <= fd_valid ? fd_pc : '0;
    end
  end

  assign dx_valid    = dx_valid_q;
  assign dx_opcode   = dx_insn[OPCODE_LSB +: OPCODE_W];
  assign dx_rd       = dx_insn[RD_LSB +: REG_W];
  assign dx_rs       = dx_insn[RS_LSB +: REG_W];
  assign dx_rt       = dx_insn[RT_LSB +: REG_W];
  assign dx_shamt    = dx_insn[SHAMT_LSB +: SHAMT_W];
  assign dx_aluop    = dx_insn[ALUOP_LSB +: ALUOP_W];
  assign dx_imm17    = dx_insn[IMM_LSB +: IMM_W];
  assign dx_target   = dx_insn[TARGET_LSB +: TARGET_W];
  assign dx_pc       = dx_pc_q;
  assign stall_count = stall_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage against a cycle-level reference model of the decode rules.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset, f_valid, x_is_load, flush;
  logic [31:0] f_insn, f_pc;
  logic [4:0]  x_rd;
  logic        stall_f, dx_valid;
  logic [4:0]  dx_opcode, dx_rd, dx_rs, dx_rt, dx_shamt, dx_aluop;
  logic [16:0] dx_imm17;
  logic [26:0] dx_target;
  logic [31:0] dx_pc, stall_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state: what sits in F/D and D/X, and the stall tally.
  logic        m_fd_v, m_dx_v;
  logic [31:0] m_fd_insn, m_fd_pc, m_dx_insn, m_dx_pc, m_cnt;

  decode_stage #(.W(32)) dut (
    .clock(clock), .reset(reset), .f_valid(f_valid), .f_insn(f_insn), .f_pc(f_pc),
    .x_is_load(x_is_load), .x_rd(x_rd), .flush(flush), .stall_f(stall_f),
    .dx_valid(dx_valid), .dx_opcode(dx_opcode), .dx_rd(dx_rd), .dx_rs(dx_rs),
    .dx_rt(dx_rt), .dx_shamt(dx_shamt), .dx_aluop(dx_aluop), .dx_imm17(dx_imm17),
    .dx_target(dx_target), .dx_pc(dx_pc), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int unsigned op, input int unsigned rd,
                                     input int unsigned rs, input int unsigned imm);
    return (op << 27) | (rd << 22) | (rs << 17) | (imm & 32'h1FFFF);
  endfunction

  function automatic int unsigned fld(input logic [31:0] insn, input int unsigned lsb,
                                      input int unsigned width);
    return (insn >> lsb) & ((1 << width) - 1);
  endfunction

  // Hazard from the ISA's list of registers each opcode reads.
  function automatic logic model_hazard(input logic v, input logic [31:0] insn,
                                        input logic ld, input logic [4:0] xrd);
    int unsigned op, rd, rs, rt;
    int unsigned src[$];
    op = fld(insn, 27, 5); rd = fld(insn, 22, 5); rs = fld(insn, 17, 5); rt = fld(insn, 12, 5);
    case (op)
      0:       src = '{rs, rt};
      5, 8:    src = '{rs};
      2, 6, 7: src = '{rd, rs};
      4:       src = '{rd};
      22:      src = '{30};
      default: src = {};
    endcase
    if (!v || !ld || xrd == 0) return 1'b0;
    foreach (src[i]) if (src[i] == int'(xrd)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic fv, input logic [31:0] insn, input logic [31:0] pc,
                      input logic ld, input logic [4:0] xrd, input logic fl, input logic rst);
    logic hz;
    f_valid = fv; f_insn = insn; f_pc = pc; x_is_load = ld; x_rd = xrd; flush = fl; reset = rst;
    #1;
    hz = model_hazard(m_fd_v, m_fd_insn, ld, xrd);
    check("stall_f", stall_f, hz);
    @(posedge clock);
    if (rst) begin
      {m_fd_v, m_fd_insn, m_fd_pc, m_dx_v, m_dx_insn, m_dx_pc, m_cnt} = '0;
    end else if (fl) begin
      {m_fd_v, m_fd_insn, m_fd_pc, m_dx_v, m_dx_insn, m_dx_pc} = '0;
    end else if (hz) begin
      {m_dx_v, m_dx_insn, m_dx_pc} = '0;
      m_cnt = m_cnt + 1;
    end else begin
      m_dx_v    = m_fd_v;
      m_dx_insn = m_fd_v ? m_fd_insn : 32'h0;
      m_dx_pc   = m_fd_v ? m_fd_pc : 32'h0;
      m_fd_v = fv; m_fd_insn = insn; m_fd_pc = pc;
    end
    #1;
    check("dx_valid", dx_valid, m_dx_v);
    check("dx_opcode", dx_opcode, fld(m_dx_insn, 27, 5));
    check("dx_rd", dx_rd, fld(m_dx_insn, 22, 5));
    check("dx_rs", dx_rs, fld(m_dx_insn, 17, 5));
    check("dx_rt", dx_rt, fld(m_dx_insn, 12, 5));
    check("dx_shamt", dx_shamt, fld(m_dx_insn, 7, 5));
    check("dx_aluop", dx_aluop, fld(m_dx_insn, 2, 5));
    check("dx_imm17", dx_imm17, fld(m_dx_insn, 0, 17));
    check("dx_target", dx_target, fld(m_dx_insn, 0, 27));
    check("dx_pc", dx_pc, m_dx_pc);
    check("stall_count", stall_count, m_cnt);
    @(negedge clock);
  endtask

  task automatic idle(input logic ld, input logic [4:0] xrd, input logic fl, input logic rst);
    step(1'b0, 32'h0, 32'h0, ld, xrd, fl, rst);
  endtask

  initial begin
    logic [31:0] add_i, sw_i, bex_i, add0_i, rnd, insn;
    logic [4:0]  xrd;
    int unsigned ops[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 21, 22};
    {m_fd_v, m_fd_insn, m_fd_pc, m_dx_v, m_dx_insn, m_dx_pc, m_cnt} = '0;
    {reset, f_valid, x_is_load, flush} = 4'b1000;
    f_insn = '0; f_pc = '0; x_rd = '0;
    @(negedge clock);
    idle(1'b0, 5'd0, 1'b0, 1'b1);
    idle(1'b1, 5'd3, 1'b1, 1'b1);

    // addi r3,r1,0x1FFFF reaches D/X two edges after being presented
    step(1'b1, mk(5, 3, 1, 32'h1FFFF), 32'd100, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(1'b0, 5'd0, 1'b0, 1'b0);
    check("addi_opcode", dx_opcode, 5'b00101);
    check("addi_imm", dx_imm17, 17'h1FFFF);
    check("addi_valid", dx_valid, 1'b1);

    // add r5,r4,r2 behind lw r4
    add_i = mk(0, 5, 4, 0) | (32'd2 << 12);
    step(1'b1, add_i, 32'd101, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(1'b1, 5'd4, 1'b0, 1'b0);
    check("lu_bubble", dx_valid, 1'b0);
    check("lu_count", stall_count, 32'd1);
    idle(1'b0, 5'd0, 1'b0, 1'b0);
    check("lu_issue_rd", dx_rd, 5'd5);

    // sw r4,0(r6): rd is a source; r0 never stalls
    sw_i = mk(7, 4, 6, 0);
    step(1'b1, sw_i, 32'd102, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(1'b1, 5'd4, 1'b0, 1'b0);
    add0_i = mk(0, 0, 0, 0);
    step(1'b1, add0_i, 32'd103, 1'b1, 5'd0, 1'b0, 1'b0);
    idle(1'b1, 5'd0, 1'b0, 1'b0);

    // bex reads r30
    bex_i = mk(22, 0, 0, 5);
    step(1'b1, bex_i, 32'd104, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(1'b1, 5'd29, 1'b0, 1'b0);
    step(1'b1, bex_i, 32'd105, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(1'b1, 5'd30, 1'b0, 1'b0);
    idle(1'b0, 5'd0, 1'b0, 1'b0);

    // flush together with a hazard drops the stall
    step(1'b1, add_i, 32'd106, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(1'b1, 5'd4, 1'b1, 1'b0);
    step(1'b1, sw_i, 32'd107, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(1'b0, 5'd0, 1'b0, 1'b0);

    // reset during a live stall
    step(1'b1, add_i, 32'd108, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(1'b1, 5'd2, 1'b0, 1'b1);
    check("rst_count", stall_count, 32'd0);

    // counter wrap from all-ones
    step(1'b1, add_i, 32'd109, 1'b0, 5'd0, 1'b0, 1'b0);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt;
    m_cnt = 32'hFFFF_FFFF;
    idle(1'b1, 5'd4, 1'b0, 1'b0);
    check("wrap_count", stall_count, 32'd0);

    for (int i = 0; i < 400; i++) begin
      rnd  = $urandom();
      insn = (ops[$urandom_range(0, 10)] << 27) | (rnd & 32'h07FF_FFFF);
      if ($urandom_range(0, 7) == 0) insn = $urandom();
      case ($urandom_range(0, 4))
        0:       xrd = 5'(fld(m_fd_insn, 17, 5));
        1:       xrd = 5'(fld(m_fd_insn, 22, 5));
        2:       xrd = 5'(fld(m_fd_insn, 12, 5));
        3:       xrd = 5'd30;
        default: xrd = 5'($urandom_range(0, 31));
      endcase
      step(1'($urandom_range(0, 3) != 0), insn, $urandom(), 1'($urandom_range(0, 1)), xrd,
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
